// File: rtl/wb_slave_pkg.sv
// rtl/wb_slave_pkg.sv - shared types, widths and window decode for the wishbone RAM slave
package wb_slave_pkg;

  localparam int WB_DW = 32;
  localparam int WB_SW = 4;
  localparam int WB_TW = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    T_ACK,
    T_ERR,
    T_RTY
  } term_t;

  // Only the bits above the word index and byte offset select the window
  function automatic logic win_hit(input logic [31:0] adr, input logic [31:0] base, input int aw);
    return (adr >> (aw + 2)) == (base >> (aw + 2));
  endfunction

endpackage

// File: rtl/wb_slave_ram_if.sv
// rtl/wb_slave_ram_if.sv - wishbone classic bus bundle with tag and hold sideband
interface wb_slave_ram_if;
  import wb_slave_pkg::*;

  logic              cyc_i;
  logic              stb_i;
  logic              we_i;
  logic [31:0]       adr_i;
  logic [WB_SW-1:0]  sel_i;
  logic [WB_DW-1:0]  dat_i;
  logic [WB_DW-1:0]  dat_o;
  logic              ack_o;
  logic              err_o;
  logic              rty_o;
  logic [WB_TW-1:0]  tag_i;
  logic [WB_TW-1:0]  tag_o;
  logic              hold_i;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i, tag_i, hold_i,
    output dat_o, ack_o, err_o, rty_o, tag_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i, tag_i, hold_i,
    input  dat_o, ack_o, err_o, rty_o, tag_o
  );

endinterface

// File: rtl/wb_slave_ram_core.sv
// rtl/wb_slave_ram_core.sv - single-port byte-enabled RAM with registered read data
module wb_slave_ram_core
  import wb_slave_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [WB_SW-1:0] be,
  input  logic [WB_DW-1:0] wdata,
  output logic [WB_DW-1:0] rdata
);

  logic [WB_DW-1:0] mem [0:(2**AW)-1];
  logic [WB_DW-1:0] rdata_q;

  // Lane-masked write and synchronous read; a read during a write returns the old word
  always_ff @(posedge clk) begin
    if (we) begin
      for (int n = 0; n < WB_SW; n++) begin
        if (be[n]) begin
          mem[addr][8*n +: 8] <= wdata[8*n +: 8];
        end
      end
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wb_slave_ram.sv
// rtl/wb_slave_ram.sv - wishbone slave RAM with wait states, ERR/RTY terminations and tag echo
module wb_slave_ram
  import wb_slave_pkg::*;
#(
  parameter int          AW          = 8,
  parameter logic [31:0] BASE_ADR    = 32'h4000_0000,
  parameter int          WAIT_STATES = 2
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  wb_slave_ram_if.slave wb
);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             we_q, we_d;
  logic [WB_SW-1:0] sel_q, sel_d;
  logic [WB_DW-1:0] dat_q, dat_d;
  logic [WB_TW-1:0] tag_q, tag_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             rty_q, rty_d;
  logic [WB_TW-1:0] tag_o_q, tag_o_d;

  logic             req;
  logic             hit;
  logic             fire;
  term_t            term;
  logic [AW-1:0]    ram_idx;
  logic             ram_we;
  logic [WB_SW-1:0] ram_be;
  logic [WB_DW-1:0] ram_wdata;
  logic [WB_DW-1:0] ram_rdata;

  assign req = wb.cyc_i & wb.stb_i;
  assign hit = win_hit(wb.adr_i, BASE_ADR, AW);

  // Next-state, request capture and RAM port steering; the RAM is driven from the
  // live bus in IDLE so a zero-wait beat can read/write at its sampling edge
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    we_d      = we_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    tag_d     = tag_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rty_d     = 1'b0;
    tag_o_d   = '0;
    fire      = 1'b0;
    term      = T_ACK;
    ram_idx   = idx_q;
    ram_we    = 1'b0;
    ram_be    = sel_q;
    ram_wdata = dat_q;

    case (state_q)
      IDLE: begin
        ram_idx   = wb.adr_i[AW+1:2];
        ram_be    = wb.sel_i;
        ram_wdata = wb.dat_i;
        if (req) begin
          idx_d = wb.adr_i[AW+1:2];
          we_d  = wb.we_i;
          sel_d = wb.sel_i;
          dat_d = wb.dat_i;
          tag_d = wb.tag_i;
          if (!hit) begin
            fire = 1'b1;
            term = T_ERR;
          end else if (wb.hold_i) begin
            fire = 1'b1;
            term = T_RTY;
          end else if (WAIT_STATES == 0) begin
            fire   = 1'b1;
            term   = T_ACK;
            ram_we = wb.we_i;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          fire   = 1'b1;
          term   = T_ACK;
          ram_we = we_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fire) begin
      state_d = RESP;
      ack_d   = (term == T_ACK);
      err_d   = (term == T_ERR);
      rty_d   = (term == T_RTY);
      tag_o_d = tag_d;
    end

    // A write due at a reset edge is discarded
    if (RST_I) begin
      ram_we = 1'b0;
    end
  end

  // State and registered terminations
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      tag_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      tag_o_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      tag_q   <= tag_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      tag_o_q <= tag_o_d;
    end
  end

  wb_slave_ram_core #(
    .AW (AW)
  ) u_core (
    .clk   (CLK_I),
    .addr  (ram_idx),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM output register already holds the word read at the edge entering RESP
  assign wb.dat_o = ack_q ? ram_rdata : '0;
  assign wb.ack_o = ack_q;
  assign wb.err_o = err_q;
  assign wb.rty_o = rty_q;
  assign wb.tag_o = tag_o_q;

endmodule

// File: tb/tb_wb_slave_ram.sv
// tb/tb_wb_slave_ram.sv - directed self-checking bench for wb_slave_ram
module tb_wb_slave_ram;

  localparam logic [1:0] TN = 2'd0;
  localparam logic [1:0] TA = 2'd1;
  localparam logic [1:0] TE = 2'd2;
  localparam logic [1:0] TR = 2'd3;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  wb_slave_ram_if bus();

  wb_slave_ram #(
    .AW          (8),
    .BASE_ADR    (32'h4000_0000),
    .WAIT_STATES (2)
  ) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .wb    (bus)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic access(input string name, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat, input logic [3:0] tag,
                        input logic hold, input logic keep_cyc,
                        output logic [1:0] term, output logic [31:0] rd,
                        output logic [3:0] tg, output int lat);
    term = TN;
    rd   = '0;
    tg   = '0;
    lat  = 0;
    bus.cyc_i  = 1'b1;
    bus.stb_i  = 1'b1;
    bus.we_i   = we;
    bus.adr_i  = adr;
    bus.sel_i  = sel;
    bus.dat_i  = dat;
    bus.tag_i  = tag;
    bus.hold_i = hold;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.ack_o | bus.err_o | bus.rty_o) begin
        lat  = n;
        term = bus.ack_o ? TA : (bus.err_o ? TE : TR);
        rd   = bus.dat_o;
        tg   = bus.tag_o;
        check({name, " one_term"}, 32'($countones({bus.ack_o, bus.err_o, bus.rty_o})), 32'd1);
        break;
      end
    end
    bus.stb_i  = 1'b0;
    bus.cyc_i  = keep_cyc;
    bus.we_i   = 1'b0;
    bus.hold_i = 1'b0;
    @(negedge clk);
    check({name, " pulse_end"}, 32'({bus.ack_o, bus.err_o, bus.rty_o}), 32'd0);
    check({name, " dat_idle"}, bus.dat_o, 32'd0);
    check({name, " tag_idle"}, 32'(bus.tag_o), 32'd0);
  endtask

  task automatic do_write(input string name, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [3:0] tag, input logic keep_cyc);
    logic [1:0]  term;
    logic [31:0] rd;
    logic [3:0]  tg;
    int          lat;
    access(name, 1'b1, adr, sel, dat, tag, 1'b0, keep_cyc, term, rd, tg, lat);
    check({name, " term"}, 32'(term), 32'(TA));
    check({name, " lat"}, 32'(lat), 32'd3);
    check({name, " tag"}, 32'(tg), 32'(tag));
  endtask

  task automatic do_read(input string name, input logic [31:0] adr, input logic [31:0] exp,
                         input logic [3:0] tag, input logic keep_cyc);
    logic [1:0]  term;
    logic [31:0] rd;
    logic [3:0]  tg;
    int          lat;
    access(name, 1'b0, adr, 4'hF, 32'h0, tag, 1'b0, keep_cyc, term, rd, tg, lat);
    check({name, " term"}, 32'(term), 32'(TA));
    check({name, " lat"}, 32'(lat), 32'd3);
    check({name, " data"}, rd, exp);
    check({name, " tag"}, 32'(tg), 32'(tag));
  endtask

  initial begin
    logic [1:0]  term;
    logic [31:0] rd;
    logic [3:0]  tg;
    int          lat;
    int          seen;

    rst        = 1'b1;
    bus.cyc_i  = 1'b0;
    bus.stb_i  = 1'b0;
    bus.we_i   = 1'b0;
    bus.adr_i  = '0;
    bus.sel_i  = '0;
    bus.dat_i  = '0;
    bus.tag_i  = '0;
    bus.hold_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset terms", 32'({bus.ack_o, bus.err_o, bus.rty_o}), 32'd0);
    check("reset dat_o", bus.dat_o, 32'd0);
    check("reset tag_o", 32'(bus.tag_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full-word write and readback, ACK three cycles after sampling
    do_write("wr10", 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 4'h0, 1'b0);
    do_read("rd10", 32'h4000_0010, 32'hDEAD_BEEF, 4'h0, 1'b0);

    // SEL=0 write is acknowledged but changes nothing
    do_write("wr10_sel0", 32'h4000_0010, 32'h0000_0000, 4'h0, 4'h0, 1'b0);
    do_read("rd10_sel0", 32'h4000_0010, 32'hDEAD_BEEF, 4'h0, 1'b0);

    // Byte-lane merge
    do_write("wr04", 32'h4000_0004, 32'h1122_3344, 4'hF, 4'h0, 1'b0);
    do_write("wr04_lanes", 32'h4000_0004, 32'hAABB_CCDD, 4'b0101, 4'h0, 1'b0);
    do_read("rd04", 32'h4000_0004, 32'h11BB_33DD, 4'h0, 1'b0);

    // Window boundary: one past the last word errors, the last word is accepted
    access("rd400", 1'b0, 32'h4000_0400, 4'hF, 32'h0, 4'h3, 1'b0, 1'b0, term, rd, tg, lat);
    check("rd400 term", 32'(term), 32'(TE));
    check("rd400 lat", 32'(lat), 32'd1);
    check("rd400 tag", 32'(tg), 32'h3);
    do_write("wr3fc", 32'h4000_03FC, 32'hCAFE_F00D, 4'hF, 4'h0, 1'b0);
    do_read("rd3fc", 32'h4000_03FC, 32'hCAFE_F00D, 4'h0, 1'b0);

    // HOLD gives RTY without writing; retry succeeds
    do_write("wr20_init", 32'h4000_0020, 32'h0BAD_CAFE, 4'hF, 4'h0, 1'b0);
    access("wr20_hold", 1'b1, 32'h4000_0020, 4'hF, 32'h5555_5555, 4'h6, 1'b1, 1'b0, term, rd, tg, lat);
    check("wr20_hold term", 32'(term), 32'(TR));
    check("wr20_hold lat", 32'(lat), 32'd1);
    check("wr20_hold tag", 32'(tg), 32'h6);
    do_read("rd20_after_rty", 32'h4000_0020, 32'h0BAD_CAFE, 4'h0, 1'b0);
    do_write("wr20_retry", 32'h4000_0020, 32'h5555_5555, 4'hF, 4'h0, 1'b0);
    do_read("rd20_retry", 32'h4000_0020, 32'h5555_5555, 4'h0, 1'b0);

    // STB dropped during WAIT aborts the write silently
    do_write("wr30_init", 32'h4000_0030, 32'h0123_4567, 4'hF, 4'h0, 1'b0);
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b1;
    bus.adr_i = 32'h4000_0030;
    bus.sel_i = 4'hF;
    bus.dat_i = 32'hFFFF_FFFF;
    bus.tag_i = 4'h0;
    @(posedge clk);
    @(negedge clk);
    bus.stb_i = 1'b0;
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (bus.ack_o | bus.err_o | bus.rty_o) seen++;
    end
    check("abort no_term", 32'(seen), 32'd0);
    bus.cyc_i = 1'b0;
    bus.we_i  = 1'b0;
    @(negedge clk);
    do_read("rd30_abort", 32'h4000_0030, 32'h0123_4567, 4'h0, 1'b0);

    // Reset on the edge that would have acknowledged: outputs clear, write dropped
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b1;
    bus.adr_i = 32'h4000_0030;
    bus.sel_i = 4'hF;
    bus.dat_i = 32'hFFFF_FFFF;
    bus.tag_i = 4'h9;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_wait terms", 32'({bus.ack_o, bus.err_o, bus.rty_o}), 32'd0);
    check("rst_wait dat_o", bus.dat_o, 32'd0);
    check("rst_wait tag_o", 32'(bus.tag_o), 32'd0);
    rst       = 1'b0;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    @(negedge clk);
    check("rst_wait after", 32'({bus.ack_o, bus.err_o, bus.rty_o}), 32'd0);
    do_read("rd30_rst", 32'h4000_0030, 32'h0123_4567, 4'h0, 1'b0);

    // Block read with CYC held, then RMW on the second word
    for (int i = 0; i < 4; i++) begin
      do_write("blk_init", 32'h4000_0040 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 4'h0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      do_read("blk_rd", 32'h4000_0040 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hA, 1'b1);
    end
    do_read("rmw_rd", 32'h4000_0044, 32'hA000_0001, 4'hA, 1'b1);
    do_write("rmw_wr", 32'h4000_0044, 32'h5A5A_5A5A, 4'hF, 4'hA, 1'b0);
    do_read("rmw_check", 32'h4000_0044, 32'h5A5A_5A5A, 4'h0, 1'b0);
    do_read("blk_neighbour", 32'h4000_0048, 32'hA000_0002, 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/wb_slave_ram.md
Name: wb_slave_ram

Overview:
Synthesizable 32-bit WISHBONE slave: a byte-granular single-port RAM behind a fixed address window. It has a programmable number of wait states and generates ERR and RTY terminations. It is the responder end of the bench WISHBONE master bus, and serves single, block and RMW cycles with TAG echo. It is placed on the bench bus as the default memory target and reused as the register-file shell for peripheral blocks.

Parameters:
AW, 8, word-address width; memory depth is 2**AW 32-bit words
BASE_ADR, 32'h4000_0000, window base; only ADR_I[31:AW+2] is compared
WAIT_STATES, 2, extra cycles between request sample and ACK (0..15)

Ports:
CLK_I  in  1  clock, all logic on rising edge
RST_I  in  1  synchronous, active-high reset
CYC_I  in  1  bus cycle valid
STB_I  in  1  strobe, beat request
WE_I   in  1  1 = write, 0 = read
ADR_I  in  32  byte address; word index ADR_I[AW+1:2]; ADR_I[1:0] ignored
SEL_I  in  4  byte lane enables, SEL_I[n] covers DAT[8n+7:8n]
DAT_I  in  32  write data
DAT_O  out  32  read data, valid only while ACK_O=1
ACK_O  out  1  normal termination, one-cycle pulse
ERR_O  out  1  error termination, one-cycle pulse
RTY_O  out  1  retry termination, one-cycle pulse
TAG_I  in  4  master tag, sampled with the request
TAG_O  out  4  echoed tag, valid with any termination
HOLD_I in  1  target busy; a request sampled while it is high is answered with RTY

Behaviour:
- Reset (RST_I=1 at edge): state IDLE; ACK_O, ERR_O, RTY_O, DAT_O, TAG_O = 0; wait counter = 0; any pending write is dropped. RAM contents are not reset.
- States are IDLE, WAIT and RESP.
- IDLE: at an edge with CYC_I&STB_I:
  - capture ADR_I, WE_I, SEL_I, DAT_I and TAG_I into request registers;
  - window miss -> RESP with ERR;
  - else if HOLD_I -> RESP with RTY;
  - else if WAIT_STATES=0 -> RESP with ACK;
  - else -> WAIT, counter = WAIT_STATES-1.
- WAIT: decrement the counter each edge. At count 0 go to RESP with ACK. If CYC_I or STB_I is low at any edge, abort to IDLE: no termination, no write.
- RESP: exactly one termination output is high for exactly one cycle, then IDLE. CYC_I/STB_I are ignored in RESP, so one beat never gets a double ACK.
- Latency: ACK_O rises 1+WAIT_STATES cycles after the edge that sampled the request. ERR/RTY always have latency 1.
- Write: commit at the edge entering RESP-with-ACK, updating only the lanes where SEL=1. SEL=4'b0000 acknowledges with no change. ERR and RTY never write.
- Read: issue the RAM read one cycle before RESP. DAT_O is registered and valid during ACK_O; it is 0 when ACK_O=0.
- Block cycles: CYC_I held while STB_I toggles. Each beat is handled independently through IDLE, and there is a minimum of one idle cycle between beats.
- RMW: a read beat followed by a write beat to the same address; the write data is independent of the read.
- ERR_O or RTY_O is never asserted together with ACK_O.
- TAG_O carries the request tag during the termination cycle and is 0 otherwise.
- Window boundary: the last word is BASE_ADR+4*(2**AW)-4 and is accepted; BASE_ADR+4*(2**AW) gets ERR. Addresses wrap within the window only through the index bits.

Decomposition:
- Package wb_slave_pkg:
  - state enum {IDLE, WAIT, RESP};
  - termination-type enum {T_ACK, T_ERR, T_RTY};
  - constants WB_DW=32, WB_SW=4, WB_TW=4.
- Sub-module wb_slave_ram_core: single-port, byte-enabled, synchronous-read RAM with parameter AW. It holds the storage only; the FSM, decode and termination logic stay in the top.

Test Plan:
- Write 32'hDEAD_BEEF to 32'h4000_0010 with SEL=4'hF, then read it back -> read data DEAD_BEEF. With WAIT_STATES=2, ACK rises exactly 3 cycles after the request is sampled, for 1 cycle.
- Write 32'h1122_3344 to 32'h4000_0004, then write 32'hAABB_CCDD with SEL=4'b0101 -> read returns 32'h11BB_33DD.
- Read 32'h4000_0400 with AW=8 -> ERR_O for 1 cycle, no ACK. Access 32'h4000_03FC -> ACK.
- HOLD_I=1 with a write of 32'h5555_5555 to 32'h4000_0020 -> RTY_O for 1 cycle, memory unchanged. Retry with HOLD_I=0 -> ACK.
- Drop STB_I during WAIT of a write of 32'hFFFF_FFFF to 32'h4000_0030 -> no termination, word keeps its prior value. Assert RST_I during WAIT -> all outputs 0 the next cycle.
- 4-beat block read from 32'h4000_0040 with TAG_I=4'hA, then RMW of word 32'h4000_0044 -> each beat has one ACK with the correct data and TAG_O=4'hA. The RMW read returns the old value and the write lands after it.
